// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//   Memory-access pipeline stage that sits directly after execute. Non-memory
//   instructions pass aluOut through to writeback one cycle later. Loads and
//   stores run a req/ack transaction with the data memory. Load data is aligned
//   and sign/zero extended before it is registered toward writeback.
//   Misaligned, illegal and timed-out accesses raise a one-cycle exception pulse.
//
//   Sequence for a legal memory op:
//     accept (IDLE) -> REQ (1..n cycles) -> DONE -> release (IDLE)
//   stall is high from the accept cycle through DONE. In the release cycle,
//   stall is low and the instruction upstream was holding is dropped, because
//   that instruction has already been serviced.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   exValid, memRead, memWrite instruction valid / load / store
//   regWriteIn, rdIn           destination register write enable and index
//   funct3                     access size/sign (B, H, W, BU, HU)
//   aluOut, storeData          address or pass-through value; rs2 store data
//   stall                      upstream must hold this cycle
//   dmemReq/We/Addr/Be/Wdata   data-memory request, held until dmemAck
//   dmemAck, dmemRdata         memory handshake and read word
//   wbValid/wbRegWrite/wbRd/wbData   registered writeback result (pulse)
//   memExc, excCause           exception pulse; cause held until next exception
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int TIMEOUT   = 255,  // REQ cycles without ack before bus error; 0 = never
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        regWriteIn,
  input  logic [4:0]  rdIn,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluOut,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [3:0]  dmemBe,
  output logic [31:0] dmemWdata,
  input  logic        dmemAck,
  input  logic [31:0] dmemRdata,
  output logic        wbValid,
  output logic        wbRegWrite,
  output logic [4:0]  wbRd,
  output logic [31:0] wbData,
  output logic        memExc,
  output logic [1:0]  excCause
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

  // Counter value in the last REQ cycle that is allowed to see an ack.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t              state, stateNext;
  logic                releaseCycle;   // IDLE cycle right after DONE
  logic [TIMEOUT_W-1:0] reqCnt;
  logic                busErr;

  // Captured transaction context
  logic [4:0]          rdQ;
  logic [2:0]          f3Q;
  logic [1:0]          offQ;
  logic                isLoadQ;
  logic                regWrQ;
  logic [31:0]         rdataQ;

  // Decode
  logic                memOp, illegal, misaligned;
  logic                issue, accept, fault, passThru, timedOut;
  logic [3:0]          beNext;
  logic [31:0]         wdataNext;
  logic [7:0]          byteSel;
  logic [15:0]         halfSel;
  logic [31:0]         loadResult;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    memOp      = memRead | memWrite;
    illegal    = 1'b0;
    if (memRead && memWrite)
      illegal = 1'b1;
    else if (memWrite)
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
    else
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

    misaligned = ((funct3[1:0] == 2'b01) && aluOut[0]) ||
                 ((funct3[1:0] == 2'b10) && (aluOut[1:0] != 2'b00));

    // NOTE: rst_n is folded into the combinational accept path so stall stays
    // low while reset is held, even with a memory op presented upstream.
    issue    = rst_n && (state == IDLE) && exValid && !releaseCycle;
    accept   = issue && memOp && !illegal && !misaligned;
    fault    = issue && memOp && (illegal || misaligned);
    passThru = issue && !memOp;
    timedOut = (TIMEOUT != 0) && (state == REQ) && !dmemAck && (reqCnt == TO_LAST);
  end

  // Store lane steering
  always_comb begin
    beNext    = 4'b1111;
    wdataNext = storeData;
    case (funct3[1:0])
      2'b00: begin
        beNext    = 4'b0001 << aluOut[1:0];
        wdataNext = {4{storeData[7:0]}};
      end
      2'b01: begin
        beNext    = 4'b0011 << aluOut[1:0];
        wdataNext = {2{storeData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment and extension from the registered read word
  always_comb begin
    byteSel = rdataQ[7:0];
    case (offQ)
      2'd1:    byteSel = rdataQ[15:8];
      2'd2:    byteSel = rdataQ[23:16];
      2'd3:    byteSel = rdataQ[31:24];
      default: byteSel = rdataQ[7:0];
    endcase
    halfSel = offQ[1] ? rdataQ[31:16] : rdataQ[15:0];
    case (f3Q)
      3'b000:  loadResult = {{24{byteSel[7]}}, byteSel};
      3'b100:  loadResult = {24'd0, byteSel};
      3'b001:  loadResult = {{16{halfSel[15]}}, halfSel};
      3'b101:  loadResult = {16'd0, halfSel};
      default: loadResult = rdataQ;
    endcase
  end

  // FSM next state and combinational handshake outputs
  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    dmemReq   = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) stateNext = REQ;
      end
      REQ: begin
        stall   = 1'b1;
        dmemReq = 1'b1;
        if (dmemAck || timedOut) stateNext = DONE;
      end
      DONE: begin
        stall     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      releaseCycle <= 1'b0;
      reqCnt       <= '0;
      busErr       <= 1'b0;
      rdQ          <= '0;
      f3Q          <= '0;
      offQ         <= '0;
      isLoadQ      <= 1'b0;
      regWrQ       <= 1'b0;
      rdataQ       <= '0;
      dmemWe       <= 1'b0;
      dmemAddr     <= '0;
      dmemBe       <= '0;
      dmemWdata    <= '0;
      wbValid      <= 1'b0;
      wbRegWrite   <= 1'b0;
      wbRd         <= '0;
      wbData       <= '0;
      memExc       <= 1'b0;
      excCause     <= '0;
    end else begin
      wbValid      <= 1'b0;
      memExc       <= 1'b0;
      releaseCycle <= (state == DONE);

      if (passThru) begin
        wbValid    <= 1'b1;
        wbData     <= aluOut;
        wbRd       <= rdIn;
        wbRegWrite <= regWriteIn;
      end

      if (fault) begin
        memExc   <= 1'b1;
        excCause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
      end

      if (accept) begin
        rdQ       <= rdIn;
        f3Q       <= funct3;
        offQ      <= aluOut[1:0];
        isLoadQ   <= memRead;
        regWrQ    <= regWriteIn;
        reqCnt    <= '0;
        busErr    <= 1'b0;
        dmemWe    <= memWrite;
        dmemAddr  <= {aluOut[31:2], 2'b00};
        dmemBe    <= beNext;
        dmemWdata <= wdataNext;
      end

      if (state == REQ) begin
        reqCnt <= reqCnt + 1'b1;
        if (dmemAck)  rdataQ <= dmemRdata;
        if (timedOut) busErr <= 1'b1;
      end

      if (state == DONE) begin
        if (busErr) begin
          memExc   <= 1'b1;
          excCause <= CAUSE_TIMEOUT;
        end else begin
          wbValid    <= 1'b1;
          wbRd       <= rdQ;
          wbRegWrite <= isLoadQ & regWrQ;
          wbData     <= isLoadQ ? loadResult : 32'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//   Directed bench for mem_access. A second instance with TIMEOUT=4 and its
//   ack tied low covers the bus-timeout path. Inputs are driven 1 ns after the
//   rising edge, and outputs are sampled 1 ns after that.
// -----------------------------------------------------------------------------
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        exValid, memRead, memWrite, regWriteIn;
  logic [4:0]  rdIn;
  logic [2:0]  funct3;
  logic [31:0] aluOut, storeData;
  logic        dmemAck;
  logic [31:0] dmemRdata;

  logic        stall, dmemReq, dmemWe, wbValid, wbRegWrite, memExc;
  logic [31:0] dmemAddr, dmemWdata, wbData;
  logic [3:0]  dmemBe;
  logic [4:0]  wbRd;
  logic [1:0]  excCause;

  logic        toAck;
  logic        toStall, toReq, toWe, toWbValid, toWbRegWrite, toMemExc;
  logic [31:0] toAddr, toWdata, toWbData;
  logic [3:0]  toBe;
  logic [4:0]  toWbRd;
  logic [1:0]  toExcCause;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] ldData;
  logic        ldValid;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .exValid(exValid), .memRead(memRead),
    .memWrite(memWrite), .regWriteIn(regWriteIn), .rdIn(rdIn), .funct3(funct3),
    .aluOut(aluOut), .storeData(storeData), .stall(stall), .dmemReq(dmemReq),
    .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemBe(dmemBe), .dmemWdata(dmemWdata),
    .dmemAck(dmemAck), .dmemRdata(dmemRdata), .wbValid(wbValid),
    .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData), .memExc(memExc),
    .excCause(excCause)
  );

  mem_access #(.TIMEOUT(4), .TIMEOUT_W(3)) dutTo (
    .clk(clk), .rst_n(rst_n), .exValid(exValid), .memRead(memRead),
    .memWrite(memWrite), .regWriteIn(regWriteIn), .rdIn(rdIn), .funct3(funct3),
    .aluOut(aluOut), .storeData(storeData), .stall(toStall), .dmemReq(toReq),
    .dmemWe(toWe), .dmemAddr(toAddr), .dmemBe(toBe), .dmemWdata(toWdata),
    .dmemAck(toAck), .dmemRdata(dmemRdata), .wbValid(toWbValid),
    .wbRegWrite(toWbRegWrite), .wbRd(toWbRd), .wbData(toWbData), .memExc(toMemExc),
    .excCause(toExcCause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic v, input logic rd, input logic wr, input logic rw,
                       input logic [4:0] rdIdx, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd);
    exValid    = v;
    memRead    = rd;
    memWrite   = wr;
    regWriteIn = rw;
    rdIn       = rdIdx;
    funct3     = f3;
    aluOut     = alu;
    storeData  = sd;
  endtask

  // Load with ack in the first REQ cycle. Returns what writeback shows in the
  // release cycle.
  task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rdata,
                        output logic [31:0] data, output logic valid);
    cyc(); setOp(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, f3, addr, 32'd0);
    cyc(); dmemAck = 1'b1; dmemRdata = rdata;
    cyc(); dmemAck = 1'b0;
    cyc(); #1; data = wbData; valid = wbValid;
    cyc(); setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    dmemAck   = 1'b0;
    dmemRdata = 32'd0;
    toAck     = 1'b0;
    setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0);

    // Reset state
    cyc(); cyc(); #1;
    check("rst stall",    stall,    0);
    check("rst dmemReq",  dmemReq,  0);
    check("rst wbValid",  wbValid,  0);
    check("rst memExc",   memExc,   0);
    check("rst excCause", excCause, 0);
    check("rst wbData",   wbData,   0);
    cyc(); rst_n = 1'b1;

    // Two ALU pass-throughs back to back
    cyc(); setOp(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 3'd0, 32'h0000_1234, 32'd0); #1;
    check("alu1 stall", stall, 0);
    cyc(); setOp(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 3'd0, 32'h0000_5678, 32'd0); #1;
    check("alu1 wbValid", wbValid, 1);
    check("alu1 wbData",  wbData,  32'h0000_1234);
    check("alu1 wbRd",    wbRd,    5);
    check("alu1 wbRegWrite", wbRegWrite, 1);
    cyc(); setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0); #1;
    check("alu2 wbValid", wbValid, 1);
    check("alu2 wbData",  wbData,  32'h0000_5678);
    check("alu2 wbRd",    wbRd,    6);
    check("alu2 wbRegWrite", wbRegWrite, 0);
    cyc(); #1;
    check("alu2 pulse", wbValid, 0);

    // LW 0x100 with ack in the first REQ cycle
    cyc(); setOp(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 3'b010, 32'h0000_0100, 32'd0); #1;
    check("lw accept stall", stall, 1);
    check("lw accept req",   dmemReq, 0);
    cyc(); dmemAck = 1'b1; dmemRdata = 32'hDEAD_BEEF; #1;
    check("lw req",   dmemReq,  1);
    check("lw addr",  dmemAddr, 32'h0000_0100);
    check("lw be",    dmemBe,   4'hF);
    check("lw we",    dmemWe,   0);
    check("lw req stall", stall, 1);
    cyc(); dmemAck = 1'b0; #1;
    check("lw done req",   dmemReq, 0);
    check("lw done stall", stall,   1);
    check("lw done wbValid", wbValid, 0);
    cyc(); #1;
    check("lw wbValid", wbValid, 1);
    check("lw wbData",  wbData,  32'hDEAD_BEEF);
    check("lw wbRd",    wbRd,    7);
    check("lw wbRegWrite", wbRegWrite, 1);
    check("lw release stall", stall, 0);
    cyc(); setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0); #1;
    check("lw no duplicate", wbValid, 0);
    check("lw no reissue",   stall,   0);

    // Sub-word loads
    doLoad(3'b000, 32'h0000_0103, 32'h80FF_0000, ldData, ldValid);
    check("lb valid", ldValid, 1);
    check("lb data",  ldData,  32'hFFFF_FF80);
    doLoad(3'b100, 32'h0000_0103, 32'h80FF_0000, ldData, ldValid);
    check("lbu data", ldData,  32'h0000_0080);
    doLoad(3'b101, 32'h0000_0102, 32'h80FF_0000, ldData, ldValid);
    check("lhu data", ldData,  32'h0000_80FF);
    doLoad(3'b001, 32'h0000_0102, 32'h80FF_0000, ldData, ldValid);
    check("lh data",  ldData,  32'hFFFF_80FF);
    doLoad(3'b000, 32'h0000_0101, 32'h0000_7F00, ldData, ldValid);
    check("lb pos data", ldData, 32'h0000_007F);

    // SB 0x101 with ack delayed five REQ cycles
    cyc(); setOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 3'b000, 32'h0000_0101, 32'h1234_5678); #1;
    check("sb accept stall", stall, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      check("sb req held",  dmemReq,  1);
      check("sb addr held", dmemAddr, 32'h0000_0100);
    end
    check("sb be",    dmemBe,    4'b0010);
    check("sb wdata", dmemWdata, 32'h7878_7878);
    check("sb we",    dmemWe,    1);
    cyc(); dmemAck = 1'b1; #1;
    check("sb ack req", dmemReq, 1);
    cyc(); dmemAck = 1'b0; #1;
    check("sb done stall", stall, 1);
    cyc(); #1;
    check("sb wbValid",    wbValid,    1);
    check("sb wbRegWrite", wbRegWrite, 0);
    check("sb wbRd",       wbRd,       9);
    cyc(); setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0);

    // Misaligned LW
    cyc(); setOp(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 3'b010, 32'h0000_0102, 32'd0); #1;
    check("mis stall", stall,   0);
    check("mis req",   dmemReq, 0);
    cyc(); setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0); #1;
    check("mis memExc",   memExc,   1);
    check("mis excCause", excCause, 2'b01);
    check("mis wbValid",  wbValid,  0);
    check("mis req after", dmemReq, 0);
    cyc(); #1;
    check("mis pulse",      memExc,   0);
    check("mis cause held", excCause, 2'b01);

    // Read and write together
    cyc(); setOp(1'b1, 1'b1, 1'b1, 1'b1, 5'd11, 3'b010, 32'h0000_0100, 32'd0); #1;
    check("rw stall", stall, 0);
    cyc(); setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0); #1;
    check("rw memExc",   memExc,   1);
    check("rw excCause", excCause, 2'b10);
    check("rw wbValid",  wbValid,  0);

    // Misaligned SH, then a store with an unsigned size code
    cyc(); setOp(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'b001, 32'h0000_0103, 32'd0);
    cyc(); setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0); #1;
    check("sh mis memExc",   memExc,   1);
    check("sh mis excCause", excCause, 2'b01);
    cyc(); setOp(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'b100, 32'h0000_0100, 32'd0);
    cyc(); setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0); #1;
    check("sbu memExc",   memExc,   1);
    check("sbu excCause", excCause, 2'b10);

    // Bus timeout on the TIMEOUT=4 instance; the default instance is left waiting in REQ
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc(); setOp(1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 3'b010, 32'h0000_0200, 32'd0); #1;
    check("to accept stall", toStall, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check("to req", toReq, 1);
    end
    cyc(); #1;
    check("to req dropped", toReq,   0);
    check("to done stall",  toStall, 1);
    cyc(); #1;
    check("to memExc",   toMemExc,   1);
    check("to excCause", toExcCause, 2'b11);
    check("to wbValid",  toWbValid,  0);
    check("to released", toStall,    0);
    check("main still req",   dmemReq, 1);
    check("main still stall", stall,   1);

    // Reset in the middle of REQ on the default instance
    #2; rst_n = 1'b0; #1;
    check("midrst req",      dmemReq,  0);
    check("midrst stall",    stall,    0);
    check("midrst wbValid",  wbValid,  0);
    check("midrst memExc",   memExc,   0);
    check("midrst excCause", excCause, 0);
    check("midrst wbRd",     wbRd,     0);
    check("midrst addr",     dmemAddr, 0);
    check("midrst be",       dmemBe,   0);
    cyc(); rst_n = 1'b1; setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("midrst no wb",  wbValid, 0);
      check("midrst no req", dmemReq, 0);
    end

    // ALU, load, ALU
    cyc(); setOp(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 3'd0, 32'h0000_0011, 32'd0); #1;
    check("b2b alu1 stall", stall, 0);
    cyc(); setOp(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 3'b010, 32'h0000_0104, 32'd0); #1;
    check("b2b alu1 wbValid", wbValid, 1);
    check("b2b alu1 wbData",  wbData,  32'h0000_0011);
    check("b2b ld stall",     stall,   1);
    cyc(); dmemAck = 1'b1; dmemRdata = 32'hCAFE_F00D; #1;
    check("b2b alu1 pulse", wbValid, 0);
    check("b2b ld addr",    dmemAddr, 32'h0000_0104);
    cyc(); dmemAck = 1'b0;
    cyc(); #1;
    check("b2b ld wbValid", wbValid, 1);
    check("b2b ld wbData",  wbData,  32'hCAFE_F00D);
    check("b2b ld wbRd",    wbRd,    2);
    check("b2b release",    stall,   0);
    cyc(); setOp(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 3'd0, 32'h0000_0033, 32'd0); #1;
    check("b2b gap wbValid", wbValid, 0);
    check("b2b alu3 stall",  stall,   0);
    cyc(); setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0); #1;
    check("b2b alu3 wbValid", wbValid, 1);
    check("b2b alu3 wbData",  wbData,  32'h0000_0033);
    check("b2b alu3 wbRd",    wbRd,    3);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
